// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/control unit: FSM states,
// operand forwarding select codes and a register-match helper.
package hazard_pkg;

    // Halt/drain controller states
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Execute-stage operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
    localparam logic [1:0] FWD_WB  = 2'b01;  // Writeback result
    localparam logic [1:0] FWD_MEM = 2'b10;  // Memory-stage ALU result

    localparam int REG_W = 5;

    // True when a producing destination register feeds a consumer source.
    // x0 never produces a value, so it never matches.
    function automatic logic reg_match(input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward-select for one Execute-stage operand. Memory-stage results are
// younger than Writeback results, so they win when both match.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] Rs,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    output logic [1:0]       Forward
);

    // Priority select: Memory over Writeback over register file
    always_comb begin
        Forward = FWD_RF;
        if (RegWriteM && reg_match(RdM, Rs)) begin
            Forward = FWD_MEM;
        end else if (RegWriteW && reg_match(RdW, Rs)) begin
            Forward = FWD_WB;
        end else begin
            Forward = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard/control unit for the 5-stage pipeline: load-use stalls,
// branch flushes, operand forwarding, halt/drain sequencing and
// saturating debug event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             HaltReq,
    input  logic             CntClr,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    // Drain counter only needs to reach DRAIN_CYCLES-1
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_next_s;
    logic [DCW-1:0]   drain_cnt_r;
    logic [DCW-1:0]   drain_cnt_next_s;
    logic             lw_stall_s;
    logic             stall_evt_s;
    logic             halted_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    fwd_sel u_fwd_a (
        .Rs        (Rs1E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Forward   (ForwardAE)
    );

    fwd_sel u_fwd_b (
        .Rs        (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Forward   (ForwardBE)
    );

    // Load in Execute whose destination is read by the Decode instruction
    always_comb begin
        lw_stall_s = ResultSrcE0 && (reg_match(RdE, Rs1D) || reg_match(RdE, Rs2D));
    end

    // Next-state, drain counter and stall/flush outputs per state
    always_comb begin
        state_next_s     = state_r;
        drain_cnt_next_s = drain_cnt_r;
        StallF           = 1'b0;
        StallD           = 1'b0;
        FlushD           = 1'b0;
        FlushE           = 1'b0;
        stall_evt_s      = 1'b0;
        case (state_r)
            RUN: begin
                // A taken branch squashes Decode, so it masks the load-use stall
                StallF      = lw_stall_s && !PCSrcE;
                StallD      = lw_stall_s && !PCSrcE;
                FlushD      = PCSrcE;
                FlushE      = lw_stall_s || PCSrcE;
                stall_evt_s = lw_stall_s && !PCSrcE;
                if (HaltReq) begin
                    state_next_s     = DRAIN;
                    drain_cnt_next_s = '0;
                end else begin
                    state_next_s     = RUN;
                    drain_cnt_next_s = drain_cnt_r;
                end
            end
            DRAIN: begin
                // Hold Decode, feed bubbles; an in-flight branch still redirects
                StallF = !PCSrcE;
                StallD = 1'b1;
                FlushD = PCSrcE;
                FlushE = 1'b1;
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_next_s     = HALTED;
                    drain_cnt_next_s = '0;
                end else begin
                    state_next_s     = DRAIN;
                    drain_cnt_next_s = drain_cnt_r + DCW'(1);
                end
            end
            HALTED: begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushD = 1'b0;
                FlushE = 1'b1;
                if (!HaltReq) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = HALTED;
                end
            end
            default: begin
                state_next_s     = RUN;
                drain_cnt_next_s = '0;
            end
        endcase
    end

    // State, drain counter and Halted flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= RUN;
            drain_cnt_r <= '0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            drain_cnt_r <= drain_cnt_next_s;
            halted_r    <= (state_next_s == HALTED);
        end
    end

    // Saturating stall event counter; clear wins over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= '0;
        end else if (CntClr) begin
            stall_cnt_r <= '0;
        end else if (stall_evt_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Saturating flush event counter; counts taken branches in any state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt_r <= '0;
        end else if (CntClr) begin
            flush_cnt_r <= '0;
        end else if (PCSrcE && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign Halted   = halted_r;
    assign StallCnt = stall_cnt_r;
    assign FlushCnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle pushes its expected
// outputs; they are popped and compared once the outputs have settled.
module tb_hazard_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic          sf;
        logic          sd;
        logic          fd;
        logic          fe;
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          hl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, HaltReq, CntClr;
    logic          StallF, StallD, FlushD, FlushE, Halted;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] StallCnt, FlushCnt;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb_q[$];
    logic [CW-1:0] sc_m = '0;
    logic [CW-1:0] fc_m = '0;

    hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .HaltReq(HaltReq), .CntClr(CntClr),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .Halted(Halted),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0;
        PCSrcE = 1'b0; HaltReq = 1'b0; CntClr = 1'b0;
    endtask

    task automatic load_use();
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val({tag, ".sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, ".StallF"},    16'(StallF),    16'(e.sf));
            check_val({tag, ".StallD"},    16'(StallD),    16'(e.sd));
            check_val({tag, ".FlushD"},    16'(FlushD),    16'(e.fd));
            check_val({tag, ".FlushE"},    16'(FlushE),    16'(e.fe));
            check_val({tag, ".ForwardAE"}, 16'(ForwardAE), 16'(e.fa));
            check_val({tag, ".ForwardBE"}, 16'(ForwardBE), 16'(e.fb));
            check_val({tag, ".Halted"},    16'(Halted),    16'(e.hl));
            check_val({tag, ".StallCnt"},  16'(StallCnt),  16'(e.sc));
            check_val({tag, ".FlushCnt"},  16'(FlushCnt),  16'(e.fc));
        end
    endtask

    // One cycle: inputs already driven; expected current-cycle outputs given,
    // plus which counters should advance at the coming edge.
    task automatic step(input string tag, input logic sf, input logic sd,
                        input logic fd, input logic fe, input logic [1:0] fa,
                        input logic [1:0] fb, input logic hl,
                        input logic inc_s, input logic inc_f);
        exp_t e;
        e.sf = sf; e.sd = sd; e.fd = fd; e.fe = fe;
        e.fa = fa; e.fb = fb; e.hl = hl; e.sc = sc_m; e.fc = fc_m;
        sb_q.push_back(e);
        #1;
        compare(tag);
        if (CntClr) begin
            sc_m = '0;
            fc_m = '0;
        end else begin
            if (inc_s && sc_m != 4'hF) sc_m = sc_m + 4'd1;
            if (inc_f && fc_m != 4'hF) fc_m = fc_m + 4'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        clr_in();
        repeat (2) @(negedge clk);
        check_val("rst.Halted",   16'(Halted),   16'd0);
        check_val("rst.StallCnt", 16'(StallCnt), 16'd0);
        check_val("rst.FlushCnt", 16'(FlushCnt), 16'd0);
        check_val("rst.StallF",   16'(StallF),   16'd0);
        reset = 1'b0;

        // Forwarding priority
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd5;
        step("fwd_mem", 0, 0, 0, 0, 2'b10, 2'b10, 0, 0, 0);
        RegWriteM = 1'b0;
        step("fwd_wb", 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0);
        RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
        step("fwd_x0", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        RdM = 5'd5; Rs1E = 5'd5; Rs2E = 5'd9; RdW = 5'd9;
        step("fwd_mix", 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0);

        // Load-use stall, then same with RdE = x0
        clr_in(); load_use();
        step("lu", 1, 1, 0, 1, 2'b00, 2'b00, 0, 1, 0);
        clr_in(); ResultSrcE0 = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
        step("lu_x0", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

        // Branch masks load-use stall
        clr_in(); ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
        step("br_mask", 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 1);

        // Halt/resume with a branch and a load-use during drain
        clr_in(); HaltReq = 1'b1;
        step("h0_run", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("h1_drn", 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        PCSrcE = 1'b1;
        step("h2_drn_br", 0, 1, 1, 1, 2'b00, 2'b00, 0, 0, 1);
        PCSrcE = 1'b0; ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        step("h3_drn_lu", 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        clr_in(); HaltReq = 1'b1;
        step("h4_halt", 1, 1, 0, 1, 2'b00, 2'b00, 1, 0, 0);
        PCSrcE = 1'b1;
        step("h5_halt_br", 1, 1, 0, 1, 2'b00, 2'b00, 1, 0, 1);
        PCSrcE = 1'b0; HaltReq = 1'b0;
        step("h6_halt_rel", 1, 1, 0, 1, 2'b00, 2'b00, 1, 0, 0);
        step("h7_run", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

        // One-cycle halt pulse: drain still completes
        HaltReq = 1'b1;
        step("p0_run", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        HaltReq = 1'b0;
        for (int i = 0; i < 3; i++) step("p_drn", 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        step("p_halt", 1, 1, 0, 1, 2'b00, 2'b00, 1, 0, 0);
        step("p_run", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

        // Saturation of both counters
        for (int i = 0; i < 20; i++) begin
            clr_in(); load_use();
            step("sat_s", 1, 1, 0, 1, 2'b00, 2'b00, 0, 1, 0);
        end
        for (int i = 0; i < 20; i++) begin
            clr_in(); PCSrcE = 1'b1;
            step("sat_f", 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 1);
        end
        clr_in();
        #1;
        check_val("sat.StallCnt", 16'(StallCnt), 16'h000F);
        check_val("sat.FlushCnt", 16'(FlushCnt), 16'h000F);
        @(negedge clk);

        // Clear has priority over a simultaneous increment
        load_use(); PCSrcE = 1'b1; CntClr = 1'b1;
        step("clr", 0, 0, 1, 1, 2'b00, 2'b00, 0, 1, 1);
        clr_in();
        step("after_clr", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

        // Reset while draining
        load_use();
        step("pre_rst_lu", 1, 1, 0, 1, 2'b00, 2'b00, 0, 1, 0);
        clr_in(); HaltReq = 1'b1;
        step("rd_run", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("rd_drn", 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_val("mid_rst.StallF",   16'(StallF),   16'd0);
        check_val("mid_rst.FlushE",   16'(FlushE),   16'd0);
        check_val("mid_rst.Halted",   16'(Halted),   16'd0);
        check_val("mid_rst.StallCnt", 16'(StallCnt), 16'd0);
        check_val("mid_rst.FlushCnt", 16'(FlushCnt), 16'd0);
        sc_m = '0; fc_m = '0;
        @(negedge clk);
        reset = 1'b0; HaltReq = 1'b0;
        step("post_rst", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("post_rst2", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
